word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Parallel-to-serial transmitter for 10-bit words.
- Accepts a word on a one-cycle start strobe and shifts it out on a single line as a framed serial stream: start bit, data bits LSB first, then stop bit.
- It is the unload/transmit end of the 10-bit load-register datapath. The upstream register's Q drives din, and a controller pulses start.

Parameters:
- WIDTH, 10: data word width in bits. Legal values are 2 or more.
- BAUD_DIV, 4: clock cycles each serial bit is held on tx. Legal values are 1 or more.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
- start, input, 1: request to transmit din. Accepted only when ready=1.
- din, input, WIDTH: word to transmit. Sampled on the accepting edge only.
- ready, output, 1: block is idle and can accept start.
- busy, output, 1: frame in progress. Always the inverse of ready.
- tx, output, 1: serial line. Idles high.
- done, output, 1: one-cycle pulse when a frame completes.

Behaviour:
- Reset values, asserted on any rising edge with rst=1, in any state, including mid-frame:
  - state=IDLE, tx=1, ready=1, busy=0, done=0.
  - Shift register, divider count and bit count are cleared.
  - Any frame in progress is aborted. There is no partial stop bit.
- State machine: IDLE, START, DATA, STOP. A divider counts 0..BAUD_DIV-1 in every non-IDLE state.
- IDLE:
  - tx=1, ready=1.
  - On an edge with start=1: latch din into the shift register, clear the divider, go to START.
  - With start=0: stay in IDLE.
- START:
  - tx=0 for exactly BAUD_DIV cycles.
  - When the divider reaches BAUD_DIV-1: go to DATA, bit count=0.
- DATA:
  - tx = shift register bit 0.
  - At the end of each bit period: shift right by one and increment the bit count.
  - After bit WIDTH-1 has been held BAUD_DIV cycles: go to STOP.
- STOP:
  - tx=1 for BAUD_DIV cycles.
  - When the divider reaches BAUD_DIV-1: go to IDLE and assert done for that first IDLE cycle.
- Latency and frame length:
  - tx falls in the cycle following the accepting edge.
  - One full frame is (WIDTH+2)*BAUD_DIV cycles, from the first tx=0 cycle through the last stop cycle.
  - done is high in the cycle immediately after the last stop cycle.
- Outputs are registered. tx, ready and done have no combinational path from start or din.
- Handshake rules:
  - start while busy=1 is ignored, and no request is queued.
  - din changes while busy=1 have no effect on the frame in progress.
  - start is accepted in the same cycle done=1, since ready=1 in that cycle. This gives back-to-back frames with exactly one idle-high cycle between stop and the next start bit.
- Bit order: LSB first. The data bits are din[0], din[1], …, din[WIDTH-1].
- Counter widths:
  - The divider is sized to hold BAUD_DIV-1.
  - The bit count is sized to hold WIDTH-1.
  - Neither counter wraps while in use.
- BAUD_DIV=1: every bit occupies exactly one cycle and all boundary rules above still hold.
- Simultaneous rst=1 and start=1: reset wins and the start is dropped.

Test Plan:
- Reset/idle: assert rst for 2 cycles, then hold start=0 for 20 cycles. Required: tx=1, ready=1, busy=0, done=0 throughout.
- Single frame, BAUD_DIV=4, din=10'h2A5, pulse start one cycle. Required:
  - tx holds 0 for 4 cycles.
  - Then tx carries 1,0,1,0,0,1,0,1,0,1, each held 4 cycles.
  - Then tx holds 1 for 4 cycles.
  - busy=1 for exactly 48 cycles.
  - done=1 for exactly one cycle, 49 cycles after the accepting edge.
- Busy-ignore: start frame din=10'h3FF, then pulse start with din=10'h000 at cycle 10 of the frame. Required: transmitted data bits are all 1, and no second frame follows.
- Back-to-back: assert start with din=10'h001 in the done cycle of the previous frame. Required: exactly one tx=1 idle cycle between the prior stop bit and the new start bit, followed by data 1,0,0,0,0,0,0,0,0,0.
- Reset mid-frame: assert rst during data bit 5. Required: on the next cycle tx=1, ready=1, busy=0, and done never pulses for the aborted frame.
- BAUD_DIV=1, din=10'h155. Required: frame length is 12 cycles with tx sequence 0,1,0,1,0,1,0,1,0,1,0,1, and done pulses in cycle 13.

Source files
------------

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: frames a WIDTH-bit word as start bit, data LSB first,
// stop bit, each bit held BAUD_DIV clocks on tx.
module word_serializer #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             tx,
    output logic             done
);

    localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   shreg_q, shreg_n;
    logic [DIV_W-1:0]   div_q,   div_n;
    logic [BIT_W-1:0]   bit_q,   bit_n;
    logic               tx_n, ready_n, busy_n, done_n;
    logic               div_end;

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            shreg_q <= shreg_n;
            div_q   <= div_n;
            bit_q   <= bit_n;
            tx      <= tx_n;
            ready   <= ready_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register cleanly
    always_comb begin
        state_n = state_q;
        shreg_n = shreg_q;
        div_n   = div_q;
        bit_n   = bit_q;
        done_n  = 1'b0;
        div_end = (div_q == DIV_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_n = din;
                    div_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (div_end) begin
                    div_n   = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (div_end) begin
                    div_n = '0;
                    if (bit_q == BIT_LAST) begin
                        state_n = S_STOP;
                    end else begin
                        shreg_n = {1'b0, shreg_q[WIDTH-1:1]};
                        bit_n   = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            S_STOP: begin
                if (div_end) begin
                    div_n   = '0;
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                div_n   = '0;
                bit_n   = '0;
            end
        endcase

        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase

        ready_n = (state_n == S_IDLE);
        busy_n  = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: two instances (BAUD_DIV=4 and 1) share stimulus and are
// checked each cycle against a queue-of-line-bits model, plus table and directed sequences.
module tb_word_serializer;

    localparam int unsigned W = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   din;
    logic [1:0]     ready_o, busy_o, tx_o, done_o;

    word_serializer #(.WIDTH(W), .BAUD_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .din(din),
        .ready(ready_o[0]), .busy(busy_o[0]), .tx(tx_o[0]), .done(done_o[0])
    );

    word_serializer #(.WIDTH(W), .BAUD_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .din(din),
        .ready(ready_o[1]), .busy(busy_o[1]), .tx(tx_o[1]), .done(done_o[1])
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: per instance, the queue of line levels still to be sent; empty means idle.
    bit mq [2][$];
    bit exp_done [2];

    function automatic int unsigned baud(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit acc;
            acc = (rst === 1'b0) && (start === 1'b1) && (mq[i].size() == 0);
            if (rst === 1'b1) begin
                mq[i].delete();
                exp_done[i] = 1'b0;
            end else begin
                exp_done[i] = (mq[i].size() == 1);
                if (mq[i].size() > 0) void'(mq[i].pop_front());
                if (acc) begin
                    for (int k = 0; k < int'(baud(i)); k++) mq[i].push_back(1'b0);
                    for (int b = 0; b < int'(W); b++)
                        for (int k = 0; k < int'(baud(i)); k++) mq[i].push_back(din[b]);
                    for (int k = 0; k < int'(baud(i)); k++) mq[i].push_back(1'b1);
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            logic etx, erdy;
            etx  = (mq[i].size() > 0) ? mq[i][0] : 1'b1;
            erdy = (mq[i].size() == 0);
            chk($sformatf("model tx B=%0d cyc%0d", baud(i), cyc), tx_o[i], etx);
            chk($sformatf("model ready B=%0d cyc%0d", baud(i), cyc), ready_o[i], erdy);
            chk($sformatf("model busy B=%0d cyc%0d", baud(i), cyc), busy_o[i], ~erdy);
            chk($sformatf("model done B=%0d cyc%0d", baud(i), cyc), done_o[i], exp_done[i]);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, sample 1ns later.
    task automatic step(input logic r, input logic s, input logic [W-1:0] d);
        rst   = r;
        start = s;
        din   = d;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_model();
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [W+1:0] frame;    // line levels in send order, MSB sent first
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn4, dn1, bz4, z4, z1, fc;

        tbl[0] = '{din: 10'h2A5, frame: 12'b0_1010010101_1};
        tbl[1] = '{din: 10'h155, frame: 12'b0_1010101010_1};
        tbl[2] = '{din: 10'h3FF, frame: 12'b0_1111111111_1};
        tbl[3] = '{din: 10'h000, frame: 12'b0_0000000000_1};
        tbl[4] = '{din: 10'h001, frame: 12'b0_1000000000_1};
        tbl[5] = '{din: 10'h200, frame: 12'b0_0000000001_1};

        // Reset then idle
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, W'($urandom));
            chk("idle tx", tx_o[0], 1'b1);
            chk("idle ready", ready_o[0], 1'b1);
            chk("idle busy", busy_o[0], 1'b0);
            chk("idle done", done_o[0], 1'b0);
        end

        // Table: expected frame shape per word on both instances
        for (int r = 0; r < 6; r++) begin
            dn4 = 0; dn1 = 0; bz4 = 0;
            step(1'b0, 1'b0, '0);
            step(1'b0, 1'b1, tbl[r].din);
            for (int c = 0; c < 50; c++) begin
                if (c > 0) step(1'b0, 1'b0, W'($urandom));
                if (c < 48) chk($sformatf("row%0d tx4 c%0d", r, c), tx_o[0], tbl[r].frame[int'(W) + 1 - c / 4]);
                if (c < 12) chk($sformatf("row%0d tx1 c%0d", r, c), tx_o[1], tbl[r].frame[int'(W) + 1 - c]);
                if (c == 48) chk($sformatf("row%0d done4 cycle 49", r), done_o[0], 1'b1);
                if (c == 12) chk($sformatf("row%0d done1 cycle 13", r), done_o[1], 1'b1);
                dn4 += int'(done_o[0]);
                dn1 += int'(done_o[1]);
                bz4 += int'(busy_o[0]);
            end
            chk_int($sformatf("row%0d busy4 cycles", r), bz4, 48);
            chk_int($sformatf("row%0d done4 pulses", r), dn4, 1);
            chk_int($sformatf("row%0d done1 pulses", r), dn1, 1);
        end

        // Start while busy is ignored and not queued
        step(1'b0, 1'b1, 10'h3FF);
        z4 = (tx_o[0] == 1'b0) ? 1 : 0;
        z1 = (tx_o[1] == 1'b0) ? 1 : 0;
        for (int c = 2; c <= 70; c++) begin
            if (c == 10) step(1'b0, 1'b1, 10'h000);
            else         step(1'b0, 1'b0, 10'h000);
            if (c >= 5 && c <= 44) chk($sformatf("ignore data4 cycle%0d", c), tx_o[0], 1'b1);
            z4 += (tx_o[0] == 1'b0) ? 1 : 0;
            z1 += (tx_o[1] == 1'b0) ? 1 : 0;
        end
        chk_int("ignore low cycles B=4", z4, 4);
        chk_int("ignore low cycles B=1", z1, 1);

        // Back-to-back: new start accepted in the done cycle
        step(1'b0, 1'b1, 10'h2A5);
        for (int c = 2; c <= 49; c++) begin
            step(1'b0, 1'b0, 10'h000);
            if (c == 48) chk("b2b last stop tx", tx_o[0], 1'b1);
        end
        chk("b2b done cycle done", done_o[0], 1'b1);
        chk("b2b done cycle ready", ready_o[0], 1'b1);
        chk("b2b done cycle tx", tx_o[0], 1'b1);
        step(1'b0, 1'b1, 10'h001);
        chk("b2b start bit", tx_o[0], 1'b0);
        for (int c = 51; c <= 110; c++) begin
            step(1'b0, 1'b0, W'($urandom));
            if (c == 53) chk("b2b start bit end", tx_o[0], 1'b0);
            if (c == 55) chk("b2b data bit0", tx_o[0], 1'b1);
            if (c == 59) chk("b2b data bit1", tx_o[0], 1'b0);
        end

        // Reset during data bit 5 (cycles 25..28 of the frame)
        step(1'b0, 1'b1, 10'h3FF);
        for (int c = 2; c <= 26; c++) step(1'b0, 1'b0, 10'h3FF);
        step(1'b1, 1'b0, 10'h3FF);
        chk("abort tx", tx_o[0], 1'b1);
        chk("abort ready", ready_o[0], 1'b1);
        chk("abort busy", busy_o[0], 1'b0);
        fc = 0;
        for (int c = 0; c < 60; c++) begin
            step(1'b0, 1'b0, W'($urandom));
            fc += int'(done_o[0]);
        end
        chk_int("abort no done", fc, 0);

        // Reset and start together: reset wins
        step(1'b1, 1'b1, 10'h0F0);
        chk("rst+start ready", ready_o[0], 1'b1);
        step(1'b0, 1'b0, 10'h0F0);
        chk("rst+start no frame tx", tx_o[0], 1'b1);
        chk("rst+start no frame busy", busy_o[0], 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
